// File: rtl/fm_modulate.sv
// FM transmit core: integrates audio into a phase accumulator and emits cos/sin I/Q from a quarter-wave LUT.
// Optional pre-emphasis stage is enabled by defining FM_PREEMPH_EN.
module fm_modulate #(
    parameter int                 DATA_WIDTH    = 32,
    parameter int                 QUANT_BITS    = 10,
    parameter int                 PHASE_WIDTH   = 32,
    parameter int                 LUT_ADDR_BITS = 10,
    parameter logic signed [31:0] GAIN          = 32'h0800_0000
`ifdef FM_PREEMPH_EN
   ,parameter logic signed [31:0] PREEMPH_COEF  = 32'd1000
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fifo_in_empty,
    output logic                         rd_en_in,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    input  logic                         fifo_out_full,
    output logic                         wr_en_out,
    output logic signed [DATA_WIDTH-1:0] real_out,
    output logic signed [DATA_WIDTH-1:0] imag_out,
    output logic [2:0]                   dbg_state
);
    localparam int  PROD_W = 2 * DATA_WIDTH;
    localparam int  N      = 1 << LUT_ADDR_BITS;
    localparam int  LW     = QUANT_BITS + 1;
    localparam real PI_R   = 3.14159265358979323846;
    localparam logic [LUT_ADDR_BITS:0]       N_IDX    = (LUT_ADDR_BITS + 1)'(N);
    localparam logic signed [PROD_W-1:0]     GAIN_EXT = PROD_W'(GAIN);

    // Quarter-wave table built at elaboration; nested loops keep each loop short.
    function automatic logic [(N+1)*LW-1:0] build_lut();
        logic [(N+1)*LW-1:0] t;
        real x;
        int k;
        t = '0;
        for (int a = 0; a <= N / 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                k = a * 32 + b;
                if (k <= N) begin
                    x = real'(1 << QUANT_BITS) * $sin(PI_R / 2.0 * real'(k) / real'(N));
                    t[k*LW +: LW] = LW'($rtoi(x + 0.5));
                end
            end
        end
        return t;
    endfunction

    localparam logic [(N+1)*LW-1:0] LUT = build_lut();

`ifdef FM_PREEMPH_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_EMPH = 3'd1, S_PHASE = 3'd2,
                              S_LOOKUP = 3'd3, S_WRITE = 3'd4} state_t;
    localparam logic signed [PROD_W-1:0] COEF_EXT = PROD_W'(PREEMPH_COEF);
    logic signed [DATA_WIDTH-1:0] prev;
    logic signed [PROD_W-1:0]     prev_prod;
    logic signed [DATA_WIDTH-1:0] emph_value;
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_PHASE = 3'd2,
                              S_LOOKUP = 3'd3, S_WRITE = 3'd4} state_t;
`endif

    state_t                        state;
    logic [PHASE_WIDTH-1:0]        phase_acc;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [PROD_W-1:0]      sample_ext;
    logic signed [PROD_W-1:0]      product;
    logic [PHASE_WIDTH-1:0]        phase_step;
    logic [1:0]                    quad;
    logic [LUT_ADDR_BITS:0]        idx_lo;
    logic [LUT_ADDR_BITS:0]        idx_hi;
    logic [DATA_WIDTH-1:0]         t_lo;
    logic [DATA_WIDTH-1:0]         t_hi;
    logic [DATA_WIDTH-1:0]         cos_val;
    logic [DATA_WIDTH-1:0]         sin_val;

    // Handshake: a pop happens in any cycle with rd_en_in=1 (only when !fifo_in_empty);
    // a push happens in any cycle with wr_en_out=1 (only when the output FIFOs had room).
    assign rd_en_in  = reset && (state == S_IDLE) && !fifo_in_empty;
    assign dbg_state = state;

    assign sample_ext = PROD_W'(sample);
    assign product    = sample_ext * GAIN_EXT;
    assign phase_step = PHASE_WIDTH'(product >>> QUANT_BITS);

`ifdef FM_PREEMPH_EN
    assign prev_prod  = PROD_W'(prev) * COEF_EXT;
    assign emph_value = sample - DATA_WIDTH'(prev_prod >>> QUANT_BITS);
`endif

    assign quad   = phase_acc[PHASE_WIDTH-1 -: 2];
    assign idx_lo = {1'b0, phase_acc[PHASE_WIDTH-3 -: LUT_ADDR_BITS]};
    assign idx_hi = N_IDX - idx_lo;
    assign t_lo   = DATA_WIDTH'(LUT[idx_lo*LW +: LW]);
    assign t_hi   = DATA_WIDTH'(LUT[idx_hi*LW +: LW]);

    always_comb begin
        cos_val = t_hi;
        sin_val = t_lo;
        case (quad)
            2'd0: begin cos_val = t_hi;  sin_val = t_lo;  end
            2'd1: begin cos_val = -t_lo; sin_val = t_hi;  end
            2'd2: begin cos_val = -t_hi; sin_val = -t_lo; end
            2'd3: begin cos_val = t_lo;  sin_val = -t_hi; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase_acc <= '0;
            sample    <= '0;
            real_out  <= '0;
            imag_out  <= '0;
            wr_en_out <= 1'b0;
`ifdef FM_PREEMPH_EN
            prev      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_en_in) begin
                        sample <= audio_in;
`ifdef FM_PREEMPH_EN
                        state  <= S_EMPH;
`else
                        state  <= S_PHASE;
`endif
                    end
                end
`ifdef FM_PREEMPH_EN
                S_EMPH: begin
                    sample <= emph_value;
                    prev   <= sample;
                    state  <= S_PHASE;
                end
`endif
                S_PHASE: begin
                    phase_acc <= phase_acc + phase_step;
                    state     <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    // Table read lands directly in the output registers on entry to S_WRITE.
                    real_out  <= cos_val;
                    imag_out  <= sin_val;
                    wr_en_out <= !fifo_out_full;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_en_out) begin
                        wr_en_out <= 1'b0;
                        state     <= S_IDLE;
                    end else if (!fifo_out_full) begin
                        wr_en_out <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_modulate.sv
// Directed bench for fm_modulate: hand-computed I/Q for known phases, reset, stall and idle behaviour.
module tb_fm_modulate;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_in_empty = 1'b0;
    logic        rd_en_in;
    logic [31:0] audio_in = '0;
    logic        fifo_out_full = 1'b0;
    logic        wr_en_out;
    logic [31:0] real_out;
    logic [31:0] imag_out;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

`ifdef FM_PREEMPH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    fm_modulate #(
        .GAIN(32'h4000_0000)
`ifdef FM_PREEMPH_EN
       ,.PREEMPH_COEF(32'd1024)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .fifo_in_empty(fifo_in_empty),
        .rd_en_in(rd_en_in),
        .audio_in(audio_in),
        .fifo_out_full(fifo_out_full),
        .wr_en_out(wr_en_out),
        .real_out(real_out),
        .imag_out(imag_out),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sample through the pipeline with free output FIFOs.
    task automatic send(input logic [31:0] s, input logic [31:0] er, input logic [31:0] ei,
                        input string tag);
        int cyc;
        int bad;
        logic [63:0] e;
        @(negedge clock);
        audio_in = s;
        fifo_in_empty = 1'b0;
        #1;
        check({tag, "_rd_en"}, 32'(rd_en_in), 32'd1);
        exp_q.push_back({er, ei});
        cyc = 0;
        bad = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (rd_en_in) bad++;
        end while (!wr_en_out && cyc < 20);
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_no_pop_busy"}, 32'(bad), 32'd0);
        e = exp_q.pop_front();
        check({tag, "_real"}, real_out, e[63:32]);
        check({tag, "_imag"}, imag_out, e[31:0]);
        fifo_in_empty = 1'b1;
        @(negedge clock);
        check({tag, "_single_push"}, 32'(wr_en_out), 32'd0);
    endtask

    // One sample with the output FIFOs full for 10 cycles in S_WRITE.
    task automatic send_stalled(input logic [31:0] s, input logic [31:0] er, input logic [31:0] ei,
                                input string tag);
        int bad;
        logic [63:0] e;
        @(negedge clock);
        audio_in = s;
        fifo_in_empty = 1'b0;
        fifo_out_full = 1'b1;
        #1;
        check({tag, "_rd_en"}, 32'(rd_en_in), 32'd1);
        exp_q.push_back({er, ei});
        repeat (LAT) @(negedge clock);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_en_out) bad++;
            if (rd_en_in) bad++;
            if (real_out !== er || imag_out !== ei) bad++;
            if (k < 9) @(negedge clock);
        end
        check({tag, "_stall_quiet"}, 32'(bad), 32'd0);
        fifo_out_full = 1'b0;
        @(negedge clock);
        check({tag, "_release_push"}, 32'(wr_en_out), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_real"}, real_out, e[63:32]);
        check({tag, "_imag"}, imag_out, e[31:0]);
        fifo_in_empty = 1'b1;
        @(negedge clock);
        check({tag, "_single_push"}, 32'(wr_en_out), 32'd0);
    endtask

    initial begin
        int wr_cnt;
        int rd_cnt;
        // Reset with data waiting: nothing may be popped.
        repeat (3) @(negedge clock);
        check("reset_rd_en", 32'(rd_en_in), 32'd0);
        check("reset_wr_en", 32'(wr_en_out), 32'd0);
        check("reset_real", real_out, 32'd0);
        check("reset_imag", imag_out, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        fifo_in_empty = 1'b1;
        reset = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (wr_en_out) wr_cnt++;
            if (rd_en_in) rd_cnt++;
        end
        check("idle_no_write", 32'(wr_cnt), 32'd0);
        check("idle_no_pop", 32'(rd_cnt), 32'd0);

`ifdef FM_PREEMPH_EN
        send(32'd1024, 32'd0, 32'd1024, "emph_first");
        send(32'd1024, 32'd0, 32'd1024, "emph_second");
        send(32'd0, 32'd1024, 32'd0, "emph_neg_step");
`else
        // Zero audio keeps the phase at 0.
        for (int n = 0; n < 4; n++) send(32'd0, 32'd1024, 32'd0, "zero_audio");
        // Quarter-turn steps walk around the circle and wrap back to 0.
        send(32'd1024, 32'd0,          32'd1024,     "quarter_1");
        send(32'd1024, 32'hFFFF_FC00,  32'd0,        "quarter_2");
        send(32'd1024, 32'd0,          32'hFFFF_FC00, "quarter_3");
        send(32'd1024, 32'd1024,       32'd0,        "quarter_4_wrap");
        // Smallest table step: T[1]=2, T[N-1]=1024.
        send(32'd1,          32'd1024, 32'd2, "lut_index_1");
        send(32'hFFFF_FFFF,  32'd1024, 32'd0, "lut_back_to_0");
        // Eighth turn: T[512]=724.
        send(32'd512, 32'd724, 32'd724, "eighth_turn");

        // Reset asserted mid-stream while the next sample is in S_LOOKUP.
        @(negedge clock);
        audio_in = 32'd512;
        fifo_in_empty = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_real", real_out, 32'd0);
        check("midrst_imag", imag_out, 32'd0);
        check("midrst_wr_en", 32'(wr_en_out), 32'd0);
        check("midrst_rd_en", 32'(rd_en_in), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clock);
        @(negedge clock);
        fifo_in_empty = 1'b1;
        reset = 1'b1;
        send(32'd0, 32'd1024, 32'd0, "midrst_phase0");

        send(32'hFFFF_FC00, 32'd0, 32'hFFFF_FC00, "neg_quarter");
        send_stalled(32'd1024, 32'd1024, 32'd0, "backpressure");
        // 1.5 x quarter turn: phase 0x6000_0000 -> (-724, 724).
        send(32'd1536, 32'hFFFF_FD2C, 32'd724, "three_eighths");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
